// File: rtl/fft_engine_if.sv
// Stream, PE and status signals of fft_engine.
// The master side is the engine; the slave side is the surrounding system.
interface fft_engine_if #(
  parameter int WORDSIZE = 16,
  parameter int ADDRSIZE = 8
);
  logic                start;
  logic [WORDSIZE-1:0] in_data;
  logic                in_valid;
  logic                in_ready;
  logic [WORDSIZE-1:0] pe_a;
  logic [WORDSIZE-1:0] pe_b;
  logic [ADDRSIZE-1:0] pe_tw_idx;
  logic                pe_valid;
  logic [WORDSIZE-1:0] pe_a_res;
  logic [WORDSIZE-1:0] pe_b_res;
  logic [WORDSIZE-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic                busy;
  logic [ADDRSIZE-1:0] stage_num;
  logic [ADDRSIZE-1:0] counter;
  logic                done;

  modport master (
    input  start, in_data, in_valid, pe_a_res, pe_b_res, out_ready,
    output in_ready, pe_a, pe_b, pe_tw_idx, pe_valid, out_data, out_valid,
           out_last, busy, stage_num, counter, done
  );

  modport slave (
    output start, in_data, in_valid, pe_a_res, pe_b_res, out_ready,
    input  in_ready, pe_a, pe_b, pe_tw_idx, pe_valid, out_data, out_valid,
           out_last, busy, stage_num, counter, done
  );
endinterface

// File: rtl/fft_engine.sv
// Radix-2 DIF FFT sequencer and sample store driving an external fixed-latency PE.
// Define FFT_BITREV_OUT_EN to unload in natural frequency order instead of bit-reversed order.
module fft_engine #(
  parameter int WORDSIZE   = 16,
  parameter int NUMSAMPLES = 32,
  parameter int LOG2N      = 5,
  parameter int ADDRSIZE   = 8,
  parameter int PE_LAT     = 2
) (
  input logic          clk,
  input logic          rst,
  fft_engine_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_UNLOAD} state_t;

  localparam logic [ADDRSIZE-1:0] LAST_IDX   = ADDRSIZE'(NUMSAMPLES - 1);
  localparam logic [ADDRSIZE-1:0] HALF_N     = ADDRSIZE'(NUMSAMPLES / 2);
  localparam logic [ADDRSIZE-1:0] LAST_K     = ADDRSIZE'(NUMSAMPLES / 2 - 1);
  localparam logic [ADDRSIZE-1:0] LAST_STAGE = ADDRSIZE'(LOG2N - 1);
  localparam logic [3:0]          DRAIN_LAST = 4'(PE_LAT);

  state_t              state_q, state_d;
  logic [ADDRSIZE-1:0] idx_q, idx_d;
  logic [ADDRSIZE-1:0] stage_q, stage_d;
  logic [ADDRSIZE-1:0] counter_q, counter_d;
  logic [3:0]          drain_q, drain_d;
  logic [WORDSIZE-1:0] pe_a_q, pe_a_d;
  logic [WORDSIZE-1:0] pe_b_q, pe_b_d;
  logic [ADDRSIZE-1:0] tw_q, tw_d;
  logic                pe_valid_q, pe_valid_d;
  logic [WORDSIZE-1:0] out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                done_q, done_d;

  logic [WORDSIZE-1:0] mem_q [NUMSAMPLES];

  // Write-back pipeline: entry 0 is loaded on the issue edge, entry PE_LAT
  // lines up with the PE results on the bus.
  logic                wb_valid_q [PE_LAT+1];
  logic [LOG2N-1:0]    wb_top_q   [PE_LAT+1];
  logic [LOG2N-1:0]    wb_bot_q   [PE_LAT+1];

  logic [ADDRSIZE-1:0] span_c, mask_c, pos_c;
  logic [LOG2N-1:0]    top_c, bot_c;
  logic [LOG2N-1:0]    ul_j_c, ul_addr_c;

  assign span_c = HALF_N >> stage_q;
  assign mask_c = span_c - 1'b1;
  assign pos_c  = counter_q & mask_c;
  assign top_c  = LOG2N'(((counter_q & ~mask_c) << 1) | pos_c);
  assign bot_c  = top_c + LOG2N'(span_c);

  // Unload reads one sample ahead: index 0 on DRAIN exit, then j+1 per accepted beat.
  assign ul_j_c = (state_q == S_UNLOAD) ? idx_q[LOG2N-1:0] + 1'b1 : '0;

`ifdef FFT_BITREV_OUT_EN
  for (genvar gi = 0; gi < LOG2N; gi++) begin : g_bitrev
    assign ul_addr_c[gi] = ul_j_c[LOG2N-1-gi];
  end
`else
  assign ul_addr_c = ul_j_c;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    stage_d     = stage_q;
    counter_d   = counter_q;
    drain_d     = drain_q;
    pe_a_d      = pe_a_q;
    pe_b_d      = pe_b_q;
    tw_d        = tw_q;
    pe_valid_d  = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_LOAD;
          idx_d     = '0;
          stage_d   = '0;
          counter_d = '0;
        end
      end
      S_LOAD: begin
        if (bus.in_valid) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d   = S_COMPUTE;
            stage_d   = '0;
            counter_d = '0;
          end
        end
      end
      S_COMPUTE: begin
        pe_a_d     = mem_q[top_c];
        pe_b_d     = mem_q[bot_c];
        tw_d       = pos_c << stage_q;
        pe_valid_d = 1'b1;
        if (counter_q == LAST_K) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          counter_d = counter_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          if (stage_q == LAST_STAGE) begin
            // Sample 0 was last written early in the final stage, so this read
            // is safe even though the final write-back lands on this same edge.
            state_d     = S_UNLOAD;
            idx_d       = '0;
            out_data_d  = mem_q[ul_addr_c];
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
          end else begin
            state_d   = S_COMPUTE;
            stage_d   = stage_q + 1'b1;
            counter_d = '0;
          end
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_UNLOAD: begin
        if (out_valid_q && bus.out_ready) begin
          if (out_last_q) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
          end else begin
            idx_d      = idx_q + 1'b1;
            out_data_d = mem_q[ul_addr_c];
            out_last_d = ((idx_q + 1'b1) == LAST_IDX);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      stage_q     <= '0;
      counter_q   <= '0;
      drain_q     <= '0;
      pe_a_q      <= '0;
      pe_b_q      <= '0;
      tw_q        <= '0;
      pe_valid_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i <= PE_LAT; i++) begin
        wb_valid_q[i] <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      stage_q     <= stage_d;
      counter_q   <= counter_d;
      drain_q     <= drain_d;
      pe_a_q      <= pe_a_d;
      pe_b_q      <= pe_b_d;
      tw_q        <= tw_d;
      pe_valid_q  <= pe_valid_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      wb_valid_q[0] <= pe_valid_d;
      wb_top_q[0]   <= top_c;
      wb_bot_q[0]   <= bot_c;
      for (int i = 1; i <= PE_LAT; i++) begin
        wb_valid_q[i] <= wb_valid_q[i-1];
        wb_top_q[i]   <= wb_top_q[i-1];
        wb_bot_q[i]   <= wb_bot_q[i-1];
      end
    end
  end

  // Sample store: load port plus two write-back ports; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_LOAD && bus.in_valid) begin
        mem_q[idx_q[LOG2N-1:0]] <= bus.in_data;
      end
      if (wb_valid_q[PE_LAT]) begin
        mem_q[wb_top_q[PE_LAT]] <= bus.pe_a_res;
        mem_q[wb_bot_q[PE_LAT]] <= bus.pe_b_res;
      end
    end
  end

  assign bus.in_ready  = (state_q == S_LOAD);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.pe_a      = pe_a_q;
  assign bus.pe_b      = pe_b_q;
  assign bus.pe_tw_idx = tw_q;
  assign bus.pe_valid  = pe_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.stage_num = stage_q;
  assign bus.counter   = counter_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_fft_engine.sv
// Scoreboard bench for fft_engine: random/directed transforms against a
// group-by-group DIF reference model, with a behavioural delayed PE.
module tb_fft_engine;
  localparam int WS = 16, AS = 8, N = 32, LG = 5, PL = 2, HALF = N / 2;
  localparam int COMPUTE_CYC = LG * (HALF + PL + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_engine_if #(.WORDSIZE(WS), .ADDRSIZE(AS)) bus ();

  fft_engine #(.WORDSIZE(WS), .NUMSAMPLES(N), .LOG2N(LG), .ADDRSIZE(AS), .PE_LAT(PL)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct packed {logic [WS-1:0] data; logic last;} exp_t;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            pe_mode = 0;
  bit            stall_en = 1'b0;
  int            done_cnt = 0;
  int            beat_no = 0;
  exp_t          exp_q[$];
  logic [WS-1:0] x_stim [N];
  logic [WS-1:0] pa_d [PL];
  logic [WS-1:0] pb_d [PL];

  function automatic logic [WS-1:0] pe_fa(input logic [WS-1:0] a, input logic [WS-1:0] b,
                                          input logic [AS-1:0] tw);
    case (pe_mode)
      0:       return a;
      1:       return a + b;
      default: return a + b + WS'(tw);
    endcase
  endfunction

  function automatic logic [WS-1:0] pe_fb(input logic [WS-1:0] a, input logic [WS-1:0] b,
                                          input logic [AS-1:0] tw);
    case (pe_mode)
      0:       return b;
      1:       return a - b;
      default: return (a - b) ^ (WS'(tw) * 16'd771);
    endcase
  endfunction

  // Behavioural PE: results appear PL cycles after the operands.
  always @(posedge clk) begin
    pa_d[0] <= pe_fa(bus.pe_a, bus.pe_b, bus.pe_tw_idx);
    pb_d[0] <= pe_fb(bus.pe_a, bus.pe_b, bus.pe_tw_idx);
    for (int i = 1; i < PL; i++) begin
      pa_d[i] <= pa_d[i-1];
      pb_d[i] <= pb_d[i-1];
    end
  end
  assign bus.pe_a_res = pa_d[PL-1];
  assign bus.pe_b_res = pb_d[PL-1];

  function automatic int out_addr(input int j);
`ifdef FFT_BITREV_OUT_EN
    int r = 0;
    for (int b = 0; b < LG; b++) if (((j >> b) & 1) != 0) r |= 1 << (LG - 1 - b);
    return r;
`else
    return j;
`endif
  endfunction

  // Reference: each stage splits the array into groups of 2*span and pairs i with i+span.
  task automatic build_expected();
    logic [WS-1:0] v [N];
    logic [WS-1:0] a, b;
    int span;
    exp_t e;
    for (int i = 0; i < N; i++) v[i] = x_stim[i];
    for (int s = 0; s < LG; s++) begin
      span = N >> (s + 1);
      for (int g = 0; g < N; g += 2 * span) begin
        for (int i = 0; i < span; i++) begin
          a = v[g + i];
          b = v[g + i + span];
          v[g + i]        = pe_fa(a, b, AS'(i << s));
          v[g + i + span] = pe_fb(a, b, AS'(i << s));
        end
      end
    end
    for (int j = 0; j < N; j++) begin
      e.data = v[out_addr(j)];
      e.last = (j == N - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic check_reset_state();
    check("rst_ctrl_bits", {26'b0, bus.in_ready, bus.pe_valid, bus.out_valid, bus.out_last,
                            bus.busy, bus.done}, 32'd0);
    check("rst_stage_num", 32'(bus.stage_num), 32'd0);
    check("rst_counter",   32'(bus.counter), 32'd0);
    check("rst_pe_a",      32'(bus.pe_a), 32'd0);
    check("rst_pe_b",      32'(bus.pe_b), 32'd0);
    check("rst_tw_idx",    32'(bus.pe_tw_idx), 32'd0);
    check("rst_out_data",  32'(bus.out_data), 32'd0);
  endtask

  // Output monitor: pops the scoreboard on every accepted beat, checks stall hold.
  initial begin : mon_out
    logic          held;
    logic [WS-1:0] held_data;
    exp_t          e;
    held = 1'b0;
    held_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (bus.done) done_cnt++;
        if (held) begin
          n_tests++;
          if (!(bus.out_valid === 1'b1 && bus.out_data === held_data)) begin
            n_fail++;
            $display("FAIL stall_hold: got valid=%b data=%h, want valid=1 data=%h",
                     bus.out_valid, bus.out_data, held_data);
          end
        end
        held      = bus.out_valid && !bus.out_ready;
        held_data = bus.out_data;
        if (bus.out_valid && bus.out_ready) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL out_extra: got data=%h with empty scoreboard, want no beat", bus.out_data);
          end else begin
            e = exp_q.pop_front();
            if (bus.out_data !== e.data || bus.out_last !== e.last) begin
              n_fail++;
              $display("FAIL out_beat %0d: got data=%h last=%b, want data=%h last=%b",
                       beat_no, bus.out_data, bus.out_last, e.data, e.last);
            end else begin
              $display("[TB] out beat %0d data=%h last=%b ok", beat_no, bus.out_data, bus.out_last);
            end
          end
          beat_no = (beat_no + 1) % N;
        end
      end
    end
  end

  // PE-issue monitor: twiddle index per butterfly and idle gap between stages.
  initial begin : mon_pe
    int issue_n, gap, stg, k, span, want_tw;
    issue_n = 0;
    gap = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        issue_n = 0;
        gap = 0;
      end else if (bus.pe_valid) begin
        stg     = issue_n / HALF;
        k       = issue_n % HALF;
        span    = N >> (stg + 1);
        want_tw = (k % span) << stg;
        check($sformatf("tw_idx s%0d k%0d", stg, k), 32'(bus.pe_tw_idx), want_tw);
        if (issue_n > 0 && k == 0) check("stage_gap", gap, PL + 1);
        gap = 0;
        issue_n = (issue_n + 1) % (HALF * LG);
      end else begin
        gap++;
      end
    end
  end

  initial begin : drv_ready
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_en) bus.out_ready = ~bus.out_ready;
      else bus.out_ready = 1'b1;
    end
  end

  task automatic run_fft(input string tag, input int mode, input bit abort_mid,
                         input bit perturb, input bit stall);
    int  n, d0;
    bit  found;
    pe_mode  = mode;
    stall_en = stall;
    if (!abort_mid) build_expected();
    d0 = done_cnt;
    $display("[TB] transform %s start", tag);
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("in_ready_after_start", bus.in_ready, 1);
    for (int i = 0; i < N; i++) begin
      bus.in_valid = 1'b0;
      if ($urandom_range(3) == 0) begin
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = x_stim[i];
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;

    n = 0;
    found = 1'b0;
    while (!bus.out_valid && n < 2000) begin
      bus.start = (perturb && n == 30);
      if (abort_mid && bus.stage_num == 2 && bus.counter == 5) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;

    if (abort_mid) begin
      check("abort_point_reached", found, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_state();
      rst = 1'b0;
      @(posedge clk); #1;
      return;
    end

    check("load_to_first_out_valid", n, COMPUTE_CYC);
    n = 0;
    while (!bus.done && n < 2000) begin
      if (perturb) begin
        bus.in_valid = 1'($urandom_range(1));
        bus.in_data  = WS'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    check("done_seen", (n < 2000), 1);
    @(posedge clk); #1;
    check("done_one_cycle", bus.done, 0);
    check("done_pulse_count", done_cnt - d0, 1);
    check("busy_after_done", bus.busy, 0);
    check("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
    stall_en = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : main
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b0;

    for (int i = 0; i < N; i++) x_stim[i] = WS'(i);
    run_fft("ramp_identity", 0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < N; i++) x_stim[i] = (i == 0) ? 16'h2000 : 16'h0000;
    run_fft("impulse_addsub", 1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < N; i++) x_stim[i] = WS'($urandom);
    run_fft("random_stall", 2, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < N; i++) x_stim[i] = WS'($urandom);
    run_fft("random_abort", 2, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < N; i++) x_stim[i] = WS'($urandom);
    run_fft("random_after_abort", 2, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < N; i++) x_stim[i] = WS'($urandom);
    run_fft("random_perturb_stall", 2, 1'b0, 1'b1, 1'b1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fft_engine.md
# fft_engine

Parametrised, self-contained radix-2 DIF FFT sequencer and sample store: the successor to the single-stage, fixed-32-sample stage block. It loads NUMSAMPLES words over a valid/ready stream and runs all LOG2N stages back-to-back against an external fixed-latency butterfly PE. It then streams the results out, optionally in natural order. It sits between the input sample reader and the output formatter.

## Interface
- WORDSIZE, 16: sample/PE word width.
- NUMSAMPLES, 32: FFT length N. Must be a power of two, 8..256.
- LOG2N, 5: log2(NUMSAMPLES). Must match NUMSAMPLES.
- ADDRSIZE, 8: sample index width. Must be ≥ LOG2N.
- PE_LAT, 2: PE latency in cycles, 1..8.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a transform when in IDLE.
- in_data  in  WORDSIZE  load sample.
- in_valid  in  1  load sample valid.
- in_ready  out  1  high throughout LOAD.
- pe_a, pe_b  out  WORDSIZE  butterfly top/bottom operands (registered).
- pe_tw_idx  out  ADDRSIZE  twiddle index, 0..N/2-1 (registered).
- pe_valid  out  1  operands valid (registered).
- pe_a_res, pe_b_res  in  WORDSIZE  PE results, valid exactly PE_LAT cycles after the matching pe_valid.
- out_data  out  WORDSIZE  result sample.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_last  out  1  marks the final sample (index N-1).
- busy  out  1  high in every state except IDLE.
- stage_num  out  ADDRSIZE  current stage, 0..LOG2N-1.
- counter  out  ADDRSIZE  butterfly index within the stage.
- done  out  1  one-cycle pulse after the last sample is accepted.

## Operation
- States: IDLE → LOAD → COMPUTE ⇄ DRAIN → UNLOAD → IDLE.
- IDLE: start=1 → LOAD, and the load index is cleared. start is ignored in all other states.
- LOAD: each in_valid&in_ready beat writes mem[idx]=in_data and increments idx. The beat with idx=N-1 → COMPUTE with stage_num=0, counter=0.
- COMPUTE: one butterfly issued per cycle, k=counter (0..N/2-1).
  - span=N>>(stage_num+1); pos=k mod span; top=(k/span)*2*span+pos; bot=top+span.
  - Issue cycle: pe_a←mem[top], pe_b←mem[bot], pe_tw_idx←pos<<stage_num, pe_valid←1.
  - A write-back pipeline carries top/bot. PE_LAT cycles after pe_valid, mem[top]←pe_a_res and mem[bot]←pe_b_res.
  - At k=N/2-1 → DRAIN.
- DRAIN: pe_valid=0 for PE_LAT+1 cycles so every write-back of the stage lands before the next stage's reads.
  - Then, if stage_num<LOG2N-1: stage_num++, counter=0 → COMPUTE.
  - Otherwise → UNLOAD.
- UNLOAD: out_data=mem[addr(j)], j=0..N-1.
  - The beat advances on out_valid&out_ready. out_valid and out_data are held stable while out_ready=0.
  - The beat at j=N-1 has out_last=1. After it is accepted → IDLE, with done=1 for one cycle.
- No bank or address conflicts: storage is a register array with 2 read and 2 write ports.
- Arithmetic is done entirely by the PE. This block only moves words, unmodified, at WORDSIZE width.

## Timing
- Reset: state=IDLE. in_ready, pe_valid, out_valid, out_last, busy and done are 0. stage_num, counter, pe_a, pe_b, pe_tw_idx and out_data are 0. The write-back pipeline is flushed. Memory contents are not cleared.
- Reset in any state, including mid-COMPUTE or UNLOAD, aborts the transform. In-flight PE results are discarded and not written.
- start to in_ready: 1 cycle.
- Last load beat to the first pe_valid: 1 cycle.
- Compute duration: LOG2N*(N/2+PE_LAT+1) cycles. For N=32, PE_LAT=2 that is 95 cycles.
- The first out_valid rises the cycle after DRAIN exits.
- out_data is registered. The next sample appears the cycle after an accepted beat, so full throughput is 1 sample/cycle.
- An in_valid beat during a non-LOAD state is ignored.

## Configuration
- FFT_BITREV_OUT_EN defined: addr(j)=bitreverse_LOG2N(j), so output is in natural frequency order.
- FFT_BITREV_OUT_EN undefined: addr(j)=j, so output is in raw bit-reversed order. The bit-reverse logic is absent.

## Test plan
- Identity PE (res=operands), N=32, ramp input x[i]=i. Without the macro, out j = j. With the macro, out 1 = 16 and out 3 = 24.
- Reference PE model, Q2.13 impulse x[0]=0x2000, others 0. All 32 outputs equal 0x2000 (±1 LSB). done pulses once.
- N=32, PE_LAT=2: 95 cycles from the last load beat to the first out_valid. pe_valid is low for exactly 3 cycles between stages. pe_tw_idx sequence in stage 1 is 0,2,4,…,14 repeated.
- out_ready toggling every other cycle. No sample is dropped or duplicated, and out_data holds stable while stalled.
- rst asserted at stage 2, counter 5. All outputs are 0 the next cycle. A fresh start/load/compute then gives correct results.
- start pulsed during COMPUTE, and in_valid driven during UNLOAD. Both are ignored, and the results are unchanged.
